// File: rtl/program_fetch_unit.sv
// Instruction fetch front end: drives the program ROM from a fetch PC, buffers
// {pc, instr} pairs in a small prefetch FIFO and hands them to decode over valid/ready.
module program_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oRomAddress,
  input  logic [27:0] iRomInstruction,
  output logic [27:0] oInstruction,
  output logic [15:0] oInstrPC,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iRedirect,
  input  logic [15:0] iRedirectTarget,
  output logic        oFull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [15:0]   r_pc;
  logic [15:0]   r_mem_pc    [DEPTH];
  logic [27:0]   r_mem_instr [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = oValid & iReady;
  assign w_push = ~iRedirect & (~oFull | w_pop);

  // Redirect outranks push/pop; reset outranks redirect.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (iRedirect) begin
      r_pc    <= iRedirectTarget;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 16'd1;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are never visible once count is zero.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem_pc[r_wptr]    <= r_pc;
      r_mem_instr[r_wptr] <= iRomInstruction;
    end
  end

  assign oRomAddress  = r_pc;
  assign oValid       = (r_count != '0);
  assign oFull        = (r_count == FULL_COUNT);
  assign oInstruction = oValid ? r_mem_instr[r_rptr] : 28'd0;
  assign oInstrPC     = oValid ? r_mem_pc[r_rptr]    : 16'd0;

endmodule
